// File: rtl/des_key_schedule_ctrl.sv
// rtl/des_key_schedule_ctrl.sv - DES subkey sequencer, optional key parity check via DES_KEY_PARITY_CHECK_EN

// PC1: 64-bit key to 56-bit C||D, parity bits dropped
module des_pc1 (
  input  logic [63:0] i_key,
  output logic [55:0] o_cd
);
  localparam int TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  logic w_unused_par;
  assign w_unused_par = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                          i_key[24], i_key[16], i_key[8],  i_key[0]};

  // table-driven bit gather, bit 1 = MSB
  always_comb begin
    o_cd = '0;
    for (int i = 0; i < 56; i++) o_cd[55-i] = i_key[64-TAB[i]];
  end
endmodule

// PC2: 56-bit C||D to 48-bit round subkey
module des_pc2 (
  input  logic [55:0] i_cd,
  output logic [47:0] o_subkey
);
  localparam int TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic w_unused_cd;
  assign w_unused_cd = ^{i_cd[47], i_cd[38], i_cd[34], i_cd[31],
                         i_cd[21], i_cd[18], i_cd[13], i_cd[2]};

  // table-driven bit gather, bit 1 = MSB
  always_comb begin
    o_subkey = '0;
    for (int i = 0; i < 48; i++) o_subkey[47-i] = i_cd[56-TAB[i]];
  end
endmodule

module des_key_schedule_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        abort,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        last_round,
  output logic        busy,
  output logic        parity_err
);
  typedef enum logic {S_IDLE, S_ROUND} state_t;

  state_t      r_state, w_state_nxt;
  logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
  logic [3:0]  r_round_idx, w_round_nxt;
  logic        r_dec, w_dec_nxt;
  logic [55:0] w_pc1;
  logic [4:0]  w_sched_r;
  logic        w_shift_two;
  logic        w_parity_bad;

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  des_pc1 u_pc1 (.i_key(key), .o_cd(w_pc1));
  des_pc2 u_pc2 (.i_cd({r_c, r_d}), .o_subkey(subkey));

  // 1-based DES round whose shift moves C/D to the next subkey in issue order
  assign w_sched_r   = r_dec ? (5'd16 - {1'b0, r_round_idx}) : ({1'b0, r_round_idx} + 5'd2);
  assign w_shift_two = !((w_sched_r == 5'd1) || (w_sched_r == 5'd2) ||
                         (w_sched_r == 5'd9) || (w_sched_r == 5'd16));

`ifdef DES_KEY_PARITY_CHECK_EN
  logic r_parity_err;
  logic w_parity_err_nxt;
  logic [7:0] w_byte_odd;

  // each key byte must carry odd parity
  always_comb begin
    w_byte_odd = '0;
    for (int b = 0; b < 8; b++) w_byte_odd[b] = ^key[8*b +: 8];
  end
  assign w_parity_bad = ~(&w_byte_odd);
  assign w_parity_err_nxt = (r_state == S_IDLE) && key_valid && w_parity_bad;

  // one-cycle error pulse following a rejected key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity_err <= 1'b0;
    else        r_parity_err <= w_parity_err_nxt;
  end
  assign parity_err = r_parity_err;
`else
  assign w_parity_bad = 1'b0;
  assign parity_err   = 1'b0;
`endif

  // next state and C/D/round updates; abort beats a same-cycle handshake
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_round_nxt = r_round_idx;
    w_dec_nxt   = r_dec;
    case (r_state)
      S_IDLE: begin
        if (key_valid) begin
          w_dec_nxt   = decrypt;
          w_round_nxt = 4'd0;
          if (!w_parity_bad) begin
            w_state_nxt = S_ROUND;
            // decrypt starts at K16, whose cumulative rotation is 28 (identity)
            if (decrypt) begin
              w_c_nxt = w_pc1[55:28];
              w_d_nxt = w_pc1[27:0];
            end else begin
              w_c_nxt = rotl28(w_pc1[55:28], 1'b0);
              w_d_nxt = rotl28(w_pc1[27:0], 1'b0);
            end
          end
        end
      end
      S_ROUND: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = 4'd0;
        end else if (subkey_ready) begin
          if (r_round_idx == 4'd15) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_round_nxt = r_round_idx + 4'd1;
            if (r_dec) begin
              w_c_nxt = rotr28(r_c, w_shift_two);
              w_d_nxt = rotr28(r_d, w_shift_two);
            end else begin
              w_c_nxt = rotl28(r_c, w_shift_two);
              w_d_nxt = rotl28(r_d, w_shift_two);
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_d         <= '0;
      r_round_idx <= '0;
      r_dec       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_c         <= w_c_nxt;
      r_d         <= w_d_nxt;
      r_round_idx <= w_round_nxt;
      r_dec       <= w_dec_nxt;
    end
  end

  assign key_ready    = (r_state == S_IDLE);
  assign subkey_valid = (r_state == S_ROUND);
  assign busy         = (r_state != S_IDLE);
  assign round_idx    = r_round_idx;
  assign last_round   = (r_state == S_ROUND) && (r_round_idx == 4'd15);

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// tb/tb_des_key_schedule_ctrl.sv - scoreboard bench for des_key_schedule_ctrl
module tb_des_key_schedule_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, key_valid, decrypt, abort, subkey_ready;
  logic [63:0] key;
  logic        key_ready, subkey_valid, last_round, busy, parity_err;
  logic [47:0] subkey;
  logic [3:0]  round_idx;

  des_key_schedule_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .decrypt(decrypt), .abort(abort), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .subkey(subkey), .round_idx(round_idx),
    .last_round(last_round), .busy(busy), .parity_err(parity_err));

  always #5 clk = ~clk;

`ifdef DES_KEY_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  int PC1T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SH   [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct { logic [47:0] sk; logic [3:0] idx; } exp_t;
  exp_t sb[$];
  logic [47:0] mk [16];

  int n_checks = 0, n_fail = 0;
  int exp_pulses = 0, act_pulses = 0;
  bit rdy_random = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: subkey r = PC2 of PC1 halves rotated by the cumulative shift total
  function automatic void compute(input logic [63:0] k);
    logic [27:0] c0, d0, c, d;
    logic [55:0] cd;
    int tot = 0;
    for (int i = 0; i < 28; i++) begin
      c0[27-i] = k[64-PC1T[i]];
      d0[27-i] = k[64-PC1T[28+i]];
    end
    for (int r = 0; r < 16; r++) begin
      tot += SH[r];
      for (int j = 0; j < 28; j++) begin
        c[27-j] = c0[27-((j+tot)%28)];
        d[27-j] = d0[27-((j+tot)%28)];
      end
      cd = {c, d};
      for (int b = 0; b < 48; b++) mk[r][47-b] = cd[56-PC2T[b]];
    end
  endfunction

  function automatic bit parity_ok(input logic [63:0] k);
    for (int b = 0; b < 8; b++) if (($countones(k[8*b +: 8]) % 2) == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] fix_parity(input logic [63:0] k);
    logic [63:0] r = k;
    for (int b = 0; b < 8; b++) if (($countones(r[8*b +: 8]) % 2) == 0) r[8*b] = ~r[8*b];
    return r;
  endfunction

  function automatic logic [63:0] rand_key();
    return {$urandom, $urandom};
  endfunction

  task automatic push_sched(input logic [63:0] k, input logic dec);
    exp_t e;
    compute(k);
    for (int r = 0; r < 16; r++) begin
      e.idx = 4'(r);
      e.sk  = dec ? mk[15-r] : mk[r];
      sb.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // offer one key, check latency and parity response
  task automatic issue(input logic [63:0] k, input logic dec);
    int t = 0;
    bit sched;
    while (!key_ready && t < 100) begin cyc(); t++; end
    chk("key_ready_before_issue", key_ready, 1'b1);
    key = k; decrypt = dec; key_valid = 1'b1;
    sched = !PAR_EN || parity_ok(k);
    if (sched) push_sched(k, dec);
    else exp_pulses++;
    cyc();
    key_valid = 1'b0; abort = 1'b0; decrypt = 1'($urandom);
    chk("first_valid_latency", subkey_valid, sched);
    chk("parity_err_pulse", parity_err, !sched);
    if (!sched) begin
      cyc();
      chk("parity_err_one_cycle", parity_err, 1'b0);
      chk("no_subkey_after_bad_parity", subkey_valid, 1'b0);
      chk("key_ready_after_bad_parity", key_ready, 1'b1);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sb.size() != 0 || !key_ready) && t < 400) begin cyc(); t++; end
    chk("schedule_drained", 64'(sb.size()), 64'd0);
    chk("idle_after_schedule", key_ready, 1'b1);
  endtask

  task automatic wait_round(input logic [3:0] idx);
    int t = 0;
    while (!(subkey_valid && round_idx == idx) && t < 100) begin cyc(); t++; end
    chk("reach_round", {subkey_valid, round_idx}, {1'b1, idx});
  endtask

  task automatic kat(input logic dec, input logic [47:0] first, input logic [47:0] last);
    int t = 0;
    issue(64'h133457799BBCDFF1, dec);
    chk("kat_first_subkey", subkey, first);
    chk("kat_first_idx", round_idx, 4'd0);
    while (!(subkey_valid && round_idx == 4'd15) && t < 40) begin cyc(); t++; end
    chk("kat_cycles_to_last", 64'(t), 64'd15);
    chk("kat_last_subkey", subkey, last);
    chk("kat_last_round_flag", last_round, 1'b1);
    wait_done();
  endtask

  // subkey_ready driver
  initial begin
    subkey_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      subkey_ready = rdy_random ? 1'($urandom) : 1'b1;
    end
  end

  // monitor: pop and compare on every consumed subkey, check stall stability
  logic        stalled = 1'b0;
  logic [47:0] st_sk;
  logic [3:0]  st_idx;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && parity_err) act_pulses++;
    if (rst_n && subkey_valid && !abort) begin
      chk("key_ready_low_in_round", key_ready, 1'b0);
      chk("busy_in_round", busy, 1'b1);
      if (stalled) begin
        chk("stall_subkey_stable", subkey, st_sk);
        chk("stall_idx_stable", round_idx, st_idx);
      end
      if (subkey_ready) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_subkey: got idx %0d subkey %0h expected none", round_idx, subkey);
        end else begin
          e = sb.pop_front();
          chk("subkey", subkey, e.sk);
          chk("round_idx", round_idx, e.idx);
          chk("last_round", last_round, e.idx == 4'd15);
        end
      end else begin
        stalled = 1'b1; st_sk = subkey; st_idx = round_idx;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, accepts, last_acc;
    rst_n = 1'b0; key_valid = 1'b0; decrypt = 1'b0; abort = 1'b0; key = '0;
    #12;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_subkey_valid", subkey_valid, 1'b0);
    chk("rst_last_round", last_round, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_round_idx", round_idx, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc();

    kat(1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
    kat(1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072);

    rdy_random = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(rand_key(), 1'($urandom));
      wait_done();
    end
    rdy_random = 1'b0;
    cyc();

    issue(fix_parity(rand_key()), 1'b0);
    wait_round(4'd5);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    sb.delete();
    chk("abort_subkey_valid", subkey_valid, 1'b0);
    chk("abort_key_ready", key_ready, 1'b1);
    chk("abort_round_idx", round_idx, 4'd0);
    chk("abort_busy", busy, 1'b0);
    issue(fix_parity(rand_key()), 1'b1);
    wait_done();

    abort = 1'b1;
    issue(fix_parity(rand_key()), 1'b0);
    wait_done();

    issue(fix_parity(rand_key()), 1'b1);
    wait_round(4'd9);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rstmid_subkey_valid", subkey_valid, 1'b0);
    chk("rstmid_key_ready", key_ready, 1'b1);
    chk("rstmid_round_idx", round_idx, 4'd0);
    chk("rstmid_busy", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    cyc();
    issue(fix_parity(rand_key()), 1'b0);
    wait_done();

    issue(64'h133457799BBCDFF0, 1'b0);
    wait_done();

    key = fix_parity(rand_key()); decrypt = 1'($urandom); key_valid = 1'b1;
    c = 0; accepts = 0; last_acc = 0;
    while (accepts < 3 && c < 200) begin
      if (key_ready) begin
        push_sched(key, decrypt);
        if (accepts > 0) chk("key_period", 64'(c - last_acc), 64'd17);
        last_acc = c;
        accepts++;
      end
      cyc();
      c++;
      key = fix_parity(rand_key());
      decrypt = 1'($urandom);
    end
    key_valid = 1'b0;
    chk("held_valid_accepts", 64'(accepts), 64'd3);
    wait_done();

    repeat (3) cyc();
    chk("parity_pulse_count", 64'(act_pulses), 64'(exp_pulses));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
